// File: rtl/input_event_writer.sv
// input_event_writer: synchronises and debounces the board switches, turns
// each debounced change into an event word, queues the words in a small
// shift-register FIFO and writes them into a circular buffer in main memory
// through a valid/ack handshake with the memory controller.
`timescale 1ns/1ps
module input_event_writer #(
  parameter int          DEB_CYCLES = 65536,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [23:0] BASE_ADDR  = 24'h007F00,
  parameter int          RING_LEN   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  sw_raw,
  output logic [23:0] input_addr,
  output logic [15:0] input_data,
  output logic        input_valid,
  input  logic        input_ack,
  output logic        overflow,
  output logic [15:0] event_count
);

  localparam int            CW        = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEB_CYCLES - 1);
  localparam int            PW        = $clog2(FIFO_DEPTH);
  localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
  localparam logic [7:0]    RING_LAST = 8'(RING_LEN - 1);

  logic [4:0]    sync1_reg;
  logic [4:0]    sync2_reg;
  logic [4:0]    prev_sync_reg;
  logic [4:0]    stable_reg;
  logic [CW-1:0] deb_cnt_reg;
  logic [10:0]   seq_reg;
  logic [PW:0]   count_reg;
  logic          valid_reg;
  logic [7:0]    ring_idx_reg;
  logic [23:0]   addr_reg;
  logic          overflow_reg;
  logic [15:0]   event_count_reg;

  // Entry 0 of the FIFO is always the head, so input_data is a plain register.
  logic [15:0]   entry_q [FIFO_DEPTH];

  logic          deb_hold;
  logic          event_fire;
  logic          pop;
  logic          push;
  logic          full;
  logic [PW:0]   count_after_pop;
  logic [PW:0]   count_next;
  logic [15:0]   event_word;
  logic [7:0]    ring_next;

  // The counter only runs while the synchronised vector is both new and steady.
  assign deb_hold        = (sync2_reg != stable_reg) && (sync2_reg == prev_sync_reg);
  assign event_fire      = deb_hold && (deb_cnt_reg == CNT_LAST);
  assign pop             = valid_reg && input_ack;
  assign full            = (count_reg == DEPTH_C);
  // A full FIFO still takes the event when the head leaves in the same cycle.
  assign push            = event_fire && (!full || pop);
  assign count_after_pop = count_reg - (PW+1)'(pop);
  assign count_next      = count_after_pop + (PW+1)'(push);
  assign event_word      = {seq_reg, sync2_reg};
  assign ring_next       = (ring_idx_reg == RING_LAST) ? 8'd0 : ring_idx_reg + 8'd1;

  // Two-stage synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= sw_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // Shared debounce counter; a change is accepted after it holds long enough.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_sync_reg <= '0;
      stable_reg    <= '0;
      deb_cnt_reg   <= '0;
    end else begin
      prev_sync_reg <= sync2_reg;
      if (!deb_hold) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == CNT_LAST) begin
        deb_cnt_reg <= '0;
        stable_reg  <= sync2_reg;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + CW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      logic [15:0] entry_reg;
      logic [15:0] shifted;

      if (gi == FIFO_DEPTH - 1) begin : g_last
        assign shifted = entry_reg;
      end else begin : g_mid
        assign shifted = entry_q[gi+1];
      end

      assign entry_q[gi] = entry_reg;

      // Each slot shifts toward the head on a pop and captures a push landing on it.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          entry_reg <= '0;
        end else if (push && (count_after_pop == (PW+1)'(gi))) begin
          entry_reg <= event_word;
        end else if (pop) begin
          entry_reg <= shifted;
        end
      end
    end
  endgenerate

  // Occupancy, sequence numbering, ring position and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg       <= '0;
      valid_reg       <= 1'b0;
      seq_reg         <= '0;
      event_count_reg <= '0;
      overflow_reg    <= 1'b0;
      ring_idx_reg    <= '0;
      addr_reg        <= BASE_ADDR;
    end else begin
      count_reg <= count_next;
      valid_reg <= (count_next != '0);
      if (push) begin
        seq_reg         <= seq_reg + 11'd1;
        event_count_reg <= event_count_reg + 16'd1;
      end else if (event_fire) begin
        overflow_reg <= 1'b1;
      end
      if (pop) begin
        ring_idx_reg <= ring_next;
        addr_reg     <= BASE_ADDR + {16'd0, ring_next};
      end
    end
  end

  assign input_valid = valid_reg;
  assign input_data  = entry_q[0];
  assign input_addr  = addr_reg;
  assign overflow    = overflow_reg;
  assign event_count = event_count_reg;

endmodule

// File: tb/tb_input_event_writer.sv
// Bench for input_event_writer: directed scenarios plus randomized switch and
// ack traffic, compared every cycle with a queue-based reference model.
`timescale 1ns/100ps
module tb_input_event_writer;

  localparam int          DEB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [23:0] BASE  = 24'h007F00;
  localparam int          RING  = 4;

  logic        clk;
  logic        reset;
  logic [4:0]  sw_raw;
  logic [23:0] input_addr;
  logic [15:0] input_data;
  logic        input_valid;
  logic        input_ack;
  logic        overflow;
  logic [15:0] event_count;

  input_event_writer #(
    .DEB_CYCLES(DEB),
    .FIFO_DEPTH(DEPTH),
    .BASE_ADDR (BASE),
    .RING_LEN  (RING)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_raw     (sw_raw),
    .input_addr (input_addr),
    .input_data (input_data),
    .input_valid(input_valid),
    .input_ack  (input_ack),
    .overflow   (overflow),
    .event_count(event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [4:0]  pipe[$];
  logic [15:0] mq[$];
  logic [4:0]  run_val;
  int          run_len;
  logic [4:0]  m_stable;
  logic [10:0] m_seq;
  int          m_ring;
  logic        m_ovf;
  logic [15:0] m_evcnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    pipe.delete();
    pipe.push_back(5'd0);
    pipe.push_back(5'd0);
    run_val  = 5'd0;
    run_len  = 1;
    m_stable = 5'd0;
    m_seq    = 11'd0;
    m_ring   = 0;
    m_ovf    = 1'b0;
    m_evcnt  = 16'd0;
  endtask

  // One clock edge: the switch value seen by the debouncer lags two edges; a
  // new value held for DEB+1 consecutive edges and differing from the
  // accepted value becomes an event.
  task automatic model_edge(input logic [4:0] sw, input logic ack);
    logic [4:0]  s;
    logic [15:0] tmp;
    s = pipe.pop_front();
    pipe.push_back(sw);
    if (s == run_val) run_len++;
    else begin
      run_val = s;
      run_len = 1;
    end
    if (mq.size() > 0 && ack) begin
      tmp    = mq.pop_front();
      m_ring = (m_ring + 1) % RING;
    end
    if (run_len == DEB + 1 && s != m_stable) begin
      m_stable = s;
      if (mq.size() < DEPTH) begin
        mq.push_back({m_seq, s});
        m_seq   = m_seq + 11'd1;
        m_evcnt = m_evcnt + 16'd1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("valid", 32'(input_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      check("addr", 32'(input_addr), 32'(BASE + 24'(m_ring)));
      check("data", 32'(input_data), 32'(mq[0]));
    end
    check("overflow", 32'(overflow), 32'(m_ovf));
    check("event_count", 32'(event_count), 32'(m_evcnt));
  endtask

  task automatic step(input logic [4:0] sw, input logic ack);
    sw_raw    = sw;
    input_ack = ack;
    @(posedge clk);
    model_edge(sw, ack);
    #1;
    compare_all();
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic async_reset_pulse();
    #2;
    reset = 1'b0;
    model_reset();
    #0.5;
    check("rst_valid", 32'(input_valid), 32'd0);
    check("rst_addr", 32'(input_addr), 32'(BASE));
    check("rst_ovf", 32'(overflow), 32'd0);
    #0.5;
    reset = 1'b1;
  endtask

  logic [23:0] wa[8];
  logic [15:0] wd[8];
  int          nw;
  logic [23:0] exp_a[4];
  logic [15:0] exp_d[4];
  logic [4:0]  seq5[5];
  int          cyc;
  logic        seen_valid;
  logic [4:0]  cur_sw;
  int          hold_left;

  initial begin
    exp_a = '{24'h007F00, 24'h007F01, 24'h007F02, 24'h007F03};
    exp_d = '{16'h0001, 16'h0022, 16'h0044, 16'h0068};
    seq5  = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};

    // 1. Reset with switches high and random ack
    reset     = 1'b0;
    sw_raw    = 5'h1F;
    input_ack = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      input_ack = 1'($urandom_range(0, 1));
      @(posedge clk);
    end
    #1;
    check("reset_valid", 32'(input_valid), 32'd0);
    check("reset_addr", 32'(input_addr), 32'h007F00);
    check("reset_data", 32'(input_data), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_event_count", 32'(event_count), 32'd0);
    sw_raw = 5'h00;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(5'h00, 1'b0);

    // 2. Debounce latency and single write
    cyc = 0;
    do begin
      step(5'h03, 1'b0);
      cyc++;
    end while (!input_valid && cyc < 20);
    check("deb_latency", 32'(cyc), 32'd7);
    check("first_addr", 32'(input_addr), 32'h007F00);
    check("first_data", 32'(input_data), 32'h0003);
    step(5'h03, 1'b1);
    check("after_ack_valid", 32'(input_valid), 32'd0);
    check("after_ack_count", 32'(event_count), 32'd1);

    // 3. Glitch shorter than the debounce window
    for (int i = 0; i < 3; i++) step(5'h07, 1'b0);
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step(5'h03, 1'b0);
      if (input_valid) seen_valid = 1'b1;
    end
    check("glitch_no_event", 32'(seen_valid), 32'd0);
    check("glitch_count", 32'(event_count), 32'd1);

    // 4. Backpressure and overflow from a fresh reset
    sw_raw = 5'h00;
    async_reset_pulse();
    for (int i = 0; i < 3; i++) step(5'h00, 1'b0);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 8; i++) step(seq5[k], 1'b0);
    check("bp_overflow", 32'(overflow), 32'd1);
    check("bp_event_count", 32'(event_count), 32'd4);
    check("bp_head", 32'(input_data), 32'h0001);

    // 5. Drain with ack held high, then a ring wrap
    nw = 0;
    for (int i = 0; i < 10; i++) begin
      if (input_valid && nw < 8) begin
        wa[nw] = input_addr;
        wd[nw] = input_data;
        nw++;
      end
      step(5'h10, 1'b1);
    end
    check("drain_writes", 32'(nw), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_addr%0d", i), 32'(wa[i]), 32'(exp_a[i]));
      check($sformatf("drain_data%0d", i), 32'(wd[i]), 32'(exp_d[i]));
    end
    nw = 0;
    for (int i = 0; i < 12; i++) begin
      if (input_valid && nw < 8) begin
        wa[nw] = input_addr;
        wd[nw] = input_data;
        nw++;
      end
      step(5'h00, 1'b1);
    end
    check("wrap_writes", 32'(nw), 32'd1);
    check("wrap_addr", 32'(wa[0]), 32'h007F00);
    check("wrap_data", 32'(wd[0]), 32'h0080);

    // 6. Asynchronous reset while a write is pending
    for (int i = 0; i < 8; i++) step(5'h01, 1'b0);
    check("pending_valid", 32'(input_valid), 32'd1);
    sw_raw = 5'h00;
    async_reset_pulse();
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(5'h00, 1'b0);
      if (input_valid) seen_valid = 1'b1;
    end
    check("no_stale_write", 32'(seen_valid), 32'd0);
    check("post_reset_overflow", 32'(overflow), 32'd0);

    // 7. Randomized traffic with occasional resets
    cur_sw    = 5'h00;
    hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold_left == 0) begin
        cur_sw    = 5'($urandom_range(0, 31));
        hold_left = $urandom_range(1, 12);
      end
      hold_left--;
      step(cur_sw, ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/input_event_writer.md
Name: input_event_writer

Overview:
- Memory-mapped input source that feeds the memory controller's input channel (input_addr/input_data) from the board switches.
- Synchronises and debounces the raw switch vector, and turns each debounced change into an event word.
- Buffers event words in a small FIFO and writes them into a circular buffer in main memory, using a valid/ack handshake with the memory controller.
- Sits at the top level alongside the core, the memory controller and the VGA display.

Parameters:
- DEB_CYCLES, 65536: number of consecutive cycles the synchronised input must hold a new value before it is accepted (minimum 2).
- FIFO_DEPTH, 4: event FIFO depth; must be a power of two, 2..16.
- BASE_ADDR, 24'h007F00: word address of ring slot 0 in memory.
- RING_LEN, 16: number of ring slots; 1..256.

Ports:
- clk  in  1  system clock; all logic runs on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- sw_raw  in  5  unsynchronised switch inputs.
- input_addr  out  24  memory word address of the current write.
- input_data  out  16  data word of the current write.
- input_valid  out  1  a write is presented on input_addr/input_data.
- input_ack  in  1  memory controller accepted the presented write this cycle.
- overflow  out  1  sticky flag: at least one event was dropped.
- event_count  out  16  number of events accepted into the FIFO; wraps 16'hFFFF to 0.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear: synchroniser, stable vector=0, debounce counter, FIFO pointers, seq=0, ring index=0, overflow=0, event_count=0.
  - Outputs during reset: input_valid=0, input_addr=BASE_ADDR, input_data=0.
  - Reset mid-handshake: the pending FIFO contents are discarded and input_valid drops immediately, without waiting for a clock edge.
- Synchroniser: two flip-flop stages per bit, giving sync[4:0].
- Debounce:
  - One shared counter for the whole vector.
  - The counter clears when sync==stable or when sync differs from its own value in the previous cycle.
  - Otherwise the counter increments each cycle.
  - When the counter reaches DEB_CYCLES-1 while incrementing: stable<=sync, the counter clears, and an event is generated in that same cycle.
  - A pulse shorter than DEB_CYCLES cycles produces no event.
  - Latency from a sw_raw edge to event generation is 2+DEB_CYCLES cycles.
- Event word: {seq[10:0], stable_new[4:0]}, where seq is an 11-bit sequence number of accepted events.
- FIFO push:
  - An event is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - On acceptance: seq+1 and event_count+1.
  - Otherwise the event is dropped: overflow<=1 (stays set until reset); seq and event_count are unchanged.
- Write interface:
  - input_valid = FIFO not empty.
  - input_data = FIFO head word.
  - input_addr = BASE_ADDR + ring_idx, computed with 24-bit modular arithmetic.
  - These outputs come straight from registers and stay stable while valid=1 and ack=0.
  - A pop happens on any clock edge where input_valid=1 and input_ack=1. A pop advances the FIFO head and sets ring_idx to (ring_idx==RING_LEN-1) ? 0 : ring_idx+1.
  - input_ack while input_valid=0 is ignored; nothing changes.
  - Back-to-back pops are legal: if the FIFO holds more entries, input_valid stays high and the next word is presented in the following cycle.
- Simultaneous push and pop on an empty FIFO: the pushed word becomes the head in the next cycle, and input_valid=1 in that cycle.

Test Plan (DEB_CYCLES=4, FIFO_DEPTH=4, BASE_ADDR=24'h007F00, RING_LEN=4):
1. Reset: assert reset=0 with sw_raw=5'h1F and input_ack random -> input_valid=0, input_addr=24'h007F00, input_data=0, overflow=0, event_count=0.
2. Debounce: release reset, then sw_raw 0→5'h03 and hold -> input_valid rises exactly 2+4+1 cycles after the edge, with input_addr=24'h007F00 and input_data=16'h0003. Assert ack for 1 cycle -> valid=0, event_count=1.
3. Glitch reject: from stable 5'h03, pulse sw_raw=5'h07 for 3 cycles, then restore 5'h03 -> no event over 20 cycles; event_count stays 1.
4. Backpressure and overflow: hold ack=0 and apply 5 debounced changes 5'h01,5'h02,5'h04,5'h08,5'h10 -> overflow=1, event_count=4, and the head word stays at seq 0.
5. Drain and wrap (continues from scenario 4): set ack=1 continuously -> 4 consecutive writes:
   - 24'h007F00, data 16'h0001
   - 24'h007F01, data 16'h0022
   - 24'h007F02, data 16'h0044
   - 24'h007F03, data 16'h0068
   A further debounced change to 5'h00 is then written to 24'h007F00 (ring wrap) with data 16'h0080.
6. Reset mid-operation: with valid=1 and ack=0, pulse reset low for 1 ns between clock edges -> valid drops immediately; after release, no stale write is presented and overflow=0.
